// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: W-stage writeback has priority; aux writes queue in a 2-entry FIFO.
// Optional WB_TRACE_EN prints every committed non-$0 write.
module grf_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        w_we,
  input  logic [4:0]  w_a3,
  input  logic [31:0] w_wd,
  input  logic [31:0] w_pc,
  input  logic        aux_valid,
  output logic        aux_ready,
  input  logic [4:0]  aux_a3,
  input  logic [31:0] aux_wd,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] busy_mask,
  output logic        stall_req
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [1:0]  count, nxt_count;
  logic [4:0]  ent_a3 [2];
  logic [31:0] ent_wd [2];
  logic [4:0]  nxt_a3 [2];
  logic [31:0] nxt_wd [2];
  logic [2:0]  starve_cnt;
  logic        wv, push, pop, keep0, keep1;

  assign wv        = w_we && (w_a3 != '0);
  assign aux_ready = (count != 2'd2) && reset;
  assign push      = aux_valid && aux_ready && (aux_a3 != '0);
  assign pop       = !wv && (count != 2'd0);
  assign stall_req = (starve_cnt == LIMIT);

  always_comb begin
    grf_we = 1'b0;
    grf_a3 = '0;
    grf_wd = '0;
    if (wv) begin
      grf_we = 1'b1;
      grf_a3 = w_a3;
      grf_wd = w_wd;
    end else if (count != 2'd0) begin
      grf_we = 1'b1;
      grf_a3 = ent_a3[0];
      grf_wd = ent_wd[0];
    end
  end

  always_comb begin
    busy_mask = '0;
    if (count != 2'd0) busy_mask = busy_mask | (32'd1 << ent_a3[0]);
    if (count == 2'd2) busy_mask = busy_mask | (32'd1 << ent_a3[1]);
  end

  // Survivors (after pop and same-register kill by the younger W write) are
  // compacted towards the head, then an accepted push lands in the next free slot.
  always_comb begin
    keep0  = (count != 2'd0) && !pop && !(wv && (ent_a3[0] == w_a3));
    keep1  = (count == 2'd2) && !(wv && (ent_a3[1] == w_a3));
    nxt_a3 = ent_a3;
    nxt_wd = ent_wd;
    if (keep1) begin
      if (keep0) begin
        nxt_a3[1] = ent_a3[1];
        nxt_wd[1] = ent_wd[1];
      end else begin
        nxt_a3[0] = ent_a3[1];
        nxt_wd[0] = ent_wd[1];
      end
    end
    if (push) begin
      if (keep0 || keep1) begin
        nxt_a3[1] = aux_a3;
        nxt_wd[1] = aux_wd;
      end else begin
        nxt_a3[0] = aux_a3;
        nxt_wd[0] = aux_wd;
      end
    end
    nxt_count = {1'b0, keep0} + {1'b0, keep1} + {1'b0, push};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      ent_a3[0]  <= '0;
      ent_a3[1]  <= '0;
      ent_wd[0]  <= '0;
      ent_wd[1]  <= '0;
      starve_cnt <= '0;
    end else begin
      count  <= nxt_count;
      ent_a3 <= nxt_a3;
      ent_wd <= nxt_wd;
      if (pop)
        starve_cnt <= '0;
      else if ((count != 2'd0) && wv && (starve_cnt != LIMIT))
        starve_cnt <= starve_cnt + 3'd1;
    end
  end

`ifdef WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (grf_we && (grf_a3 != '0))
      $display("@%08h: $%0d <= %08h", wv ? w_pc : 32'h0, grf_a3, grf_wd);
  end
`else
  logic unused_pc;
  assign unused_pc = ^w_pc;
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed self-checking bench for grf_wb_arbiter (default STARVE_LIMIT = 4).
module tb_grf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_we;
  logic [4:0]  w_a3;
  logic [31:0] w_wd;
  logic [31:0] w_pc;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_a3;
  logic [31:0] aux_wd;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] busy_mask;
  logic        stall_req;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  grf_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .w_we(w_we), .w_a3(w_a3), .w_wd(w_wd), .w_pc(w_pc),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_a3(aux_a3), .aux_wd(aux_wd),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd),
    .busy_mask(busy_mask), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_w(input logic we, input logic [4:0] a3, input logic [31:0] wd);
    w_we = we; w_a3 = a3; w_wd = wd; w_pc = 32'h0040_0000 + {27'd0, a3};
  endtask

  task automatic drive_aux(input logic v, input logic [4:0] a3, input logic [31:0] wd);
    aux_valid = v; aux_a3 = a3; aux_wd = wd;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_w(1'b0, 5'd0, 32'd0);
    drive_aux(1'b0, 5'd0, 32'd0);
    cyc(); cyc(); #2;
    total_cnt++;
    if ({aux_ready, grf_we, grf_a3, grf_wd, busy_mask, stall_req} !== '0) begin
      $display("FAIL reset_state: ready=%b we=%b a3=%0d wd=%h busy=%h stall=%b, want all zero",
               aux_ready, grf_we, grf_a3, grf_wd, busy_mask, stall_req);
    end else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (aux_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", aux_ready);
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_w_only();
    drive_w(1'b1, 5'd8, 32'h1234); #2;
    total_cnt++;
    if ({grf_we, grf_a3, grf_wd, busy_mask} !== {1'b1, 5'd8, 32'h1234, 32'h0})
      $display("FAIL w_only: we=%b a3=%0d wd=%h busy=%h, want 1/8/00001234/0", grf_we, grf_a3, grf_wd, busy_mask);
    else pass_cnt++;
    drive_w(1'b1, 5'd0, 32'h5555); #2;
    total_cnt++;
    if (grf_we !== 1'b0) $display("FAIL w_zero_reg: grf_we=%b want 0", grf_we);
    else pass_cnt++;
    cyc();
    drive_w(1'b0, 5'd0, 32'd0);
    cyc();
  endtask

  task automatic test_aux_idle();
    drive_aux(1'b1, 5'd5, 32'hDEAD); #2;
    total_cnt++;
    if ({aux_ready, grf_we} !== 2'b10) $display("FAIL aux_accept: ready=%b we=%b want 1/0", aux_ready, grf_we);
    else pass_cnt++;
    cyc();
    drive_aux(1'b0, 5'd0, 32'd0); #2;
    total_cnt++;
    if ({grf_we, grf_a3, grf_wd, busy_mask} !== {1'b1, 5'd5, 32'hDEAD, 32'h20})
      $display("FAIL aux_write: we=%b a3=%0d wd=%h busy=%h, want 1/5/0000dead/20", grf_we, grf_a3, grf_wd, busy_mask);
    else pass_cnt++;
    cyc(); #2;
    total_cnt++;
    if ({grf_we, busy_mask} !== {1'b0, 32'h0}) $display("FAIL aux_drained: we=%b busy=%h want 0/0", grf_we, busy_mask);
    else pass_cnt++;
    // aux request to $0 is accepted but discarded
    drive_aux(1'b1, 5'd0, 32'hBAD0);
    cyc();
    drive_aux(1'b0, 5'd0, 32'd0); #2;
    total_cnt++;
    if ({grf_we, busy_mask} !== {1'b0, 32'h0}) $display("FAIL aux_zero_discard: we=%b busy=%h want 0/0", grf_we, busy_mask);
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_full();
    drive_w(1'b1, 5'd1, 32'h111);
    drive_aux(1'b1, 5'd3, 32'h33);
    cyc();
    drive_aux(1'b1, 5'd4, 32'h44);
    cyc();
    drive_aux(1'b1, 5'd6, 32'h66); #2;
    total_cnt++;
    if ({aux_ready, grf_a3, grf_wd, busy_mask} !== {1'b0, 5'd1, 32'h111, 32'h18})
      $display("FAIL full_block: ready=%b a3=%0d wd=%h busy=%h, want 0/1/00000111/18", aux_ready, grf_a3, grf_wd, busy_mask);
    else pass_cnt++;
    cyc();
    drive_w(1'b0, 5'd0, 32'd0); #2;
    total_cnt++;
    if ({aux_ready, grf_we, grf_a3, grf_wd} !== {1'b0, 1'b1, 5'd3, 32'h33})
      $display("FAIL full_pop_first: ready=%b we=%b a3=%0d wd=%h, want 0/1/3/00000033", aux_ready, grf_we, grf_a3, grf_wd);
    else pass_cnt++;
    cyc();
    drive_aux(1'b0, 5'd0, 32'd0); #2;
    total_cnt++;
    if ({grf_we, grf_a3, grf_wd, busy_mask} !== {1'b1, 5'd4, 32'h44, 32'h10})
      $display("FAIL full_pop_second: we=%b a3=%0d wd=%h busy=%h, want 1/4/00000044/10", grf_we, grf_a3, grf_wd, busy_mask);
    else pass_cnt++;
    cyc(); #2;
    total_cnt++;
    if ({grf_we, busy_mask} !== {1'b0, 32'h0}) $display("FAIL full_empty: we=%b busy=%h want 0/0", grf_we, busy_mask);
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_back_to_back();
    drive_aux(1'b1, 5'd5, 32'h55);
    cyc();
    drive_aux(1'b1, 5'd6, 32'h66); #2;
    total_cnt++;
    if ({aux_ready, grf_we, grf_a3} !== {1'b1, 1'b1, 5'd5})
      $display("FAIL b2b_pushpop: ready=%b we=%b a3=%0d want 1/1/5", aux_ready, grf_we, grf_a3);
    else pass_cnt++;
    cyc();
    drive_aux(1'b0, 5'd0, 32'd0); #2;
    total_cnt++;
    if ({grf_a3, grf_wd, busy_mask} !== {5'd6, 32'h66, 32'h40})
      $display("FAIL b2b_head: a3=%0d wd=%h busy=%h want 6/00000066/40", grf_a3, grf_wd, busy_mask);
    else pass_cnt++;
    cyc(); #2;
    total_cnt++;
    if (busy_mask !== 32'h0) $display("FAIL b2b_empty: busy=%h want 0", busy_mask);
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_starve();
    drive_aux(1'b1, 5'd7, 32'h77);
    cyc();
    drive_aux(1'b0, 5'd0, 32'd0);
    drive_w(1'b1, 5'd2, 32'h22);
    for (int j = 1; j <= 6; j++) begin
      #2;
      total_cnt++;
      if (stall_req !== (j >= 5)) $display("FAIL starve_cycle%0d: stall=%b want %b", j, stall_req, (j >= 5));
      else pass_cnt++;
      cyc();
    end
    drive_w(1'b0, 5'd0, 32'd0); #2;
    total_cnt++;
    if ({grf_we, grf_a3, stall_req} !== {1'b1, 5'd7, 1'b1})
      $display("FAIL starve_pop: we=%b a3=%0d stall=%b want 1/7/1", grf_we, grf_a3, stall_req);
    else pass_cnt++;
    cyc(); #2;
    total_cnt++;
    if ({stall_req, busy_mask} !== {1'b0, 32'h0}) $display("FAIL starve_clear: stall=%b busy=%h want 0/0", stall_req, busy_mask);
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_kill();
    drive_aux(1'b1, 5'd9, 32'h99);
    cyc();
    drive_w(1'b1, 5'd1, 32'h5);
    drive_aux(1'b1, 5'd11, 32'hBB); #2;
    total_cnt++;
    if (busy_mask !== 32'h200) $display("FAIL kill_busy9: busy=%h want 00000200", busy_mask);
    else pass_cnt++;
    cyc();
    drive_aux(1'b0, 5'd0, 32'd0);
    drive_w(1'b1, 5'd9, 32'hABC); #2;
    total_cnt++;
    if ({grf_a3, grf_wd, busy_mask} !== {5'd9, 32'hABC, 32'hA00})
      $display("FAIL kill_wwins: a3=%0d wd=%h busy=%h want 9/00000abc/a00", grf_a3, grf_wd, busy_mask);
    else pass_cnt++;
    cyc();
    drive_w(1'b0, 5'd0, 32'd0); #2;
    total_cnt++;
    if ({grf_we, grf_a3, grf_wd, busy_mask} !== {1'b1, 5'd11, 32'hBB, 32'h800})
      $display("FAIL kill_compact: we=%b a3=%0d wd=%h busy=%h want 1/11/000000bb/800", grf_we, grf_a3, grf_wd, busy_mask);
    else pass_cnt++;
    cyc(); #2;
    total_cnt++;
    if ({grf_we, busy_mask} !== {1'b0, 32'h0}) $display("FAIL kill_empty: we=%b busy=%h want 0/0", grf_we, busy_mask);
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_reset_midop();
    drive_w(1'b1, 5'd1, 32'h1);
    drive_aux(1'b1, 5'd3, 32'h3);
    cyc();
    drive_aux(1'b1, 5'd4, 32'h4);
    cyc();
    drive_aux(1'b0, 5'd0, 32'd0);
    cyc(); cyc(); cyc(); #2;
    total_cnt++;
    if ({stall_req, busy_mask} !== {1'b1, 32'h18}) $display("FAIL midop_pre: stall=%b busy=%h want 1/18", stall_req, busy_mask);
    else pass_cnt++;
    reset = 1'b0; #1;
    total_cnt++;
    if ({busy_mask, aux_ready, stall_req} !== '0)
      $display("FAIL midop_async: busy=%h ready=%b stall=%b want 0/0/0", busy_mask, aux_ready, stall_req);
    else pass_cnt++;
    drive_w(1'b0, 5'd0, 32'd0);
    cyc();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      total_cnt++;
      if ({grf_we, aux_ready} !== 2'b01) $display("FAIL midop_after%0d: we=%b ready=%b want 0/1", k, grf_we, aux_ready);
      else pass_cnt++;
      cyc();
    end
  endtask

  initial begin
    fork
      begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
      end
    join_none
    test_reset();
    test_w_only();
    test_aux_idle();
    test_full();
    test_back_to_back();
    test_starve();
    test_kill();
    test_reset_midop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
